// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: the queue entry layout,
// the fetch FSM states and PC helpers.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched instructions and their predictions
// until decode consumes them; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         enq_i,
  input  fetch_entry_t                 enq_entry_i,
  input  logic                         deq_i,
  output logic                         valid_o,
  output fetch_entry_t                 head_o,
  output logic [$clog2(FQ_DEPTH):0]    count_o
);

  localparam int unsigned AW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem_q [FQ_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          deq_ok;
  logic          full;

  assign deq_ok  = deq_i && valid_o;
  assign full    = (count_q == CW'(FQ_DEPTH));
  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (deq_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(enq_i) - CW'(deq_ok);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (enq_i && !flush_i && !rst_i) mem_q[wr_ptr_q] <= enq_entry_i;
  end

  a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(enq_i && !flush_i && full));

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the fetch PC, issues one I-mem request and BTB lookup
// per cycle, steers on next-cycle BTB hits and buffers results for decode.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        fetch_clk,
  input  logic        fetch_reset,
  input  logic        fetch_redirect,
  input  logic [31:0] fetch_redirect_pc,
  output logic [31:0] fetch_btb_pc,
  input  logic        fetch_btb_hit,
  input  logic [31:0] fetch_btb_target,
  output logic        fetch_imem_req,
  output logic [31:0] fetch_imem_addr,
  input  logic        fetch_imem_ready,
  input  logic [31:0] fetch_imem_rdata,
  output logic        fetch_dec_valid,
  input  logic        fetch_dec_ready,
  output logic [31:0] fetch_dec_pc,
  output logic [31:0] fetch_dec_instr,
  output logic        fetch_dec_pred_taken,
  output logic [31:0] fetch_dec_pred_target
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          look_pend_q, look_pend_d;
  logic [31:0]   look_pc_q, look_pc_d;

  logic [31:0]   nf;
  logic          deq, enq, accepted, issue_ok;
  logic [CW:0]   credit;
  logic [CW-1:0] count;
  fetch_entry_t  enq_entry, head;

  always_ff @(posedge fetch_clk) begin
    if (fetch_reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      look_pend_q <= 1'b0;
      look_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      look_pend_q <= look_pend_d;
      look_pc_q   <= look_pc_d;
    end
  end

  // Credits count queued entries plus the in-flight response, so an accepted
  // request always has a slot waiting for it.
  always_comb begin
    state_d        = state_q;
    nf             = (look_pend_q && fetch_btb_hit) ? word_align(fetch_btb_target) : pc_q;
    deq            = fetch_dec_valid && fetch_dec_ready && !fetch_redirect;
    credit         = {1'b0, count} + {{CW{1'b0}}, look_pend_q} - {{CW{1'b0}}, deq};
    issue_ok       = (credit < (CW + 1)'(FQ_DEPTH)) && !fetch_redirect;
    fetch_imem_req = 1'b0;

    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        state_d        = ST_RUN;
        fetch_imem_req = issue_ok;
      end
    endcase

    accepted = fetch_imem_req && fetch_imem_ready;

    if (fetch_redirect) pc_d = word_align(fetch_redirect_pc);
    else if (accepted)  pc_d = nf + 32'(INSTR_BYTES);
    else                pc_d = nf;

    look_pend_d = accepted;
    look_pc_d   = accepted ? nf : look_pc_q;
    enq         = look_pend_q && !fetch_redirect;

    enq_entry.pc          = look_pc_q;
    enq_entry.instr       = fetch_imem_rdata;
    enq_entry.pred_taken  = fetch_btb_hit;
    enq_entry.pred_target = word_align(fetch_btb_target);
  end

  assign fetch_imem_addr       = nf;
  assign fetch_btb_pc          = nf;
  assign fetch_dec_pc          = head.pc;
  assign fetch_dec_instr       = head.instr;
  assign fetch_dec_pred_taken  = head.pred_taken;
  assign fetch_dec_pred_target = head.pred_target;

  fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk_i       (fetch_clk),
    .rst_i       (fetch_reset),
    .flush_i     (fetch_redirect),
    .enq_i       (enq),
    .enq_entry_i (enq_entry),
    .deq_i       (deq),
    .valid_o     (fetch_dec_valid),
    .head_o      (head),
    .count_o     (count)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a one-cycle-latency memory model
// returning ~addr and a single-entry BTB model.
module tb_fetch_pc_unit;

  logic        fetch_clk;
  logic        fetch_reset;
  logic        fetch_redirect;
  logic [31:0] fetch_redirect_pc;
  logic [31:0] fetch_btb_pc;
  logic        fetch_btb_hit;
  logic [31:0] fetch_btb_target;
  logic        fetch_imem_req;
  logic [31:0] fetch_imem_addr;
  logic        fetch_imem_ready;
  logic [31:0] fetch_imem_rdata;
  logic        fetch_dec_valid;
  logic        fetch_dec_ready;
  logic [31:0] fetch_dec_pc;
  logic [31:0] fetch_dec_instr;
  logic        fetch_dec_pred_taken;
  logic [31:0] fetch_dec_pred_target;

  logic        btbEn    = 1'b0;
  logic [31:0] btbMatch = 32'h104;
  int          checks   = 0;
  int          errors   = 0;

  fetch_pc_unit #(
    .RESET_PC (32'h0000_0100),
    .FQ_DEPTH (4)
  ) dut (
    .fetch_clk             (fetch_clk),
    .fetch_reset           (fetch_reset),
    .fetch_redirect        (fetch_redirect),
    .fetch_redirect_pc     (fetch_redirect_pc),
    .fetch_btb_pc          (fetch_btb_pc),
    .fetch_btb_hit         (fetch_btb_hit),
    .fetch_btb_target      (fetch_btb_target),
    .fetch_imem_req        (fetch_imem_req),
    .fetch_imem_addr       (fetch_imem_addr),
    .fetch_imem_ready      (fetch_imem_ready),
    .fetch_imem_rdata      (fetch_imem_rdata),
    .fetch_dec_valid       (fetch_dec_valid),
    .fetch_dec_ready       (fetch_dec_ready),
    .fetch_dec_pc          (fetch_dec_pc),
    .fetch_dec_instr       (fetch_dec_instr),
    .fetch_dec_pred_taken  (fetch_dec_pred_taken),
    .fetch_dec_pred_target (fetch_dec_pred_target)
  );

  initial fetch_clk = 1'b0;
  always #5 fetch_clk = ~fetch_clk;

  assign fetch_btb_target = 32'h0000_0200;

  initial begin
    fetch_imem_rdata = '0;
    fetch_btb_hit    = 1'b0;
  end

  always @(posedge fetch_clk) begin
    if (fetch_imem_req && fetch_imem_ready) fetch_imem_rdata <= ~fetch_imem_addr;
    fetch_btb_hit <= btbEn && (fetch_btb_pc == btbMatch);
  end

  task automatic tick();
    @(posedge fetch_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] rpc,
                               input logic memRdy, input logic decRdy);
    fetch_reset       = rst;
    fetch_redirect    = redir;
    fetch_redirect_pc = rpc;
    fetch_imem_ready  = memRdy;
    fetch_dec_ready   = decRdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Leaves the DUT in its BOOT cycle with reset released.
  task automatic doReset(input logic decRdy);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, decRdy);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, decRdy);
  endtask

  initial begin
    $display("[TB] reset and boot");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("rst_req",      {31'b0, fetch_imem_req},       32'h0);
    checkOutput("rst_valid",    {31'b0, fetch_dec_valid},      32'h0);
    checkOutput("rst_taken",    {31'b0, fetch_dec_pred_taken}, 32'h0);
    checkOutput("rst_pc",       fetch_dec_pc,                  32'h0);
    checkOutput("rst_instr",    fetch_dec_instr,               32'h0);
    checkOutput("rst_target",   fetch_dec_pred_target,         32'h0);
    checkOutput("rst_addr",     fetch_imem_addr,               32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("boot_req",     {31'b0, fetch_imem_req},       32'h0);
    tick();
    checkOutput("c1_req",       {31'b0, fetch_imem_req},       32'h1);
    checkOutput("c1_addr",      fetch_imem_addr,               32'h100);
    checkOutput("c1_btbpc",     fetch_btb_pc,                  32'h100);
    tick();
    checkOutput("c2_addr",      fetch_imem_addr,               32'h104);
    checkOutput("c2_valid",     {31'b0, fetch_dec_valid},      32'h0);
    tick();
    checkOutput("c3_addr",      fetch_imem_addr,               32'h108);
    checkOutput("c3_valid",     {31'b0, fetch_dec_valid},      32'h1);
    checkOutput("c3_decpc",     fetch_dec_pc,                  32'h100);
    checkOutput("c3_instr",     fetch_dec_instr,               ~32'h100);
    checkOutput("c3_taken",     {31'b0, fetch_dec_pred_taken}, 32'h0);
    tick();
    checkOutput("c4_addr",      fetch_imem_addr,               32'h10C);
    checkOutput("c4_decpc",     fetch_dec_pc,                  32'h104);

    $display("[TB] predicted taken");
    doReset(1'b1);
    btbEn = 1'b1;
    tick();
    checkOutput("bt_c1_addr",   fetch_imem_addr,               32'h100);
    tick();
    checkOutput("bt_c2_addr",   fetch_imem_addr,               32'h104);
    tick();
    checkOutput("bt_c3_addr",   fetch_imem_addr,               32'h200);
    checkOutput("bt_c3_req",    {31'b0, fetch_imem_req},       32'h1);
    checkOutput("bt_c3_decpc",  fetch_dec_pc,                  32'h100);
    tick();
    checkOutput("bt_c4_addr",   fetch_imem_addr,               32'h204);
    checkOutput("bt_c4_decpc",  fetch_dec_pc,                  32'h104);
    checkOutput("bt_c4_instr",  fetch_dec_instr,               ~32'h104);
    checkOutput("bt_c4_taken",  {31'b0, fetch_dec_pred_taken}, 32'h1);
    checkOutput("bt_c4_target", fetch_dec_pred_target,         32'h200);
    tick();
    checkOutput("bt_c5_decpc",  fetch_dec_pc,                  32'h200);
    checkOutput("bt_c5_taken",  {31'b0, fetch_dec_pred_taken}, 32'h0);

    $display("[TB] memory stall after hit");
    doReset(1'b1);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("st_c3_addr",   fetch_imem_addr,               32'h200);
    tick();
    checkOutput("st_c4_addr",   fetch_imem_addr,               32'h200);
    checkOutput("st_c4_decpc",  fetch_dec_pc,                  32'h104);
    checkOutput("st_c4_taken",  {31'b0, fetch_dec_pred_taken}, 32'h1);
    tick();
    checkOutput("st_c5_addr",   fetch_imem_addr,               32'h200);
    checkOutput("st_c5_valid",  {31'b0, fetch_dec_valid},      32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("st_c6_addr",   fetch_imem_addr,               32'h200);
    checkOutput("st_c6_req",    {31'b0, fetch_imem_req},       32'h1);
    tick();
    checkOutput("st_c7_addr",   fetch_imem_addr,               32'h204);
    tick();
    checkOutput("st_c8_decpc",  fetch_dec_pc,                  32'h200);
    checkOutput("st_c8_instr",  fetch_dec_instr,               ~32'h200);
    btbEn = 1'b0;

    $display("[TB] backpressure");
    doReset(1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkOutput("bp_req_on",  {31'b0, fetch_imem_req},       32'h1);
      checkOutput("bp_addr",    fetch_imem_addr,               32'h100 + 32'(4 * (c - 1)));
    end
    tick();
    checkOutput("bp_c5_req",    {31'b0, fetch_imem_req},       32'h0);
    tick();
    checkOutput("bp_c6_req",    {31'b0, fetch_imem_req},       32'h0);
    checkOutput("bp_c6_addr",   fetch_imem_addr,               32'h110);
    checkOutput("bp_c6_decpc",  fetch_dec_pc,                  32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("bp_c6_reqr",   {31'b0, fetch_imem_req},       32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("bp_c7_req",    {31'b0, fetch_imem_req},       32'h0);
    checkOutput("bp_c7_decpc",  fetch_dec_pc,                  32'h104);
    tick();
    checkOutput("bp_c8_req",    {31'b0, fetch_imem_req},       32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("bp_c8_reqr",   {31'b0, fetch_imem_req},       32'h1);
    checkOutput("bp_c8_addr",   fetch_imem_addr,               32'h114);
    checkOutput("bp_c8_decpc",  fetch_dec_pc,                  32'h104);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("bp_drain_pc", fetch_dec_pc,                 32'h108 + 32'(4 * k));
      checkOutput("bp_drain_v",  {31'b0, fetch_dec_valid},     32'h1);
    end

    $display("[TB] redirect with pending response");
    doReset(1'b0);
    for (int c = 1; c <= 5; c++) tick();
    applyStimulus(1'b0, 1'b1, 32'h400, 1'b1, 1'b1);
    checkOutput("rd_c5_valid",  {31'b0, fetch_dec_valid},      32'h1);
    checkOutput("rd_c5_req",    {31'b0, fetch_imem_req},       32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rd_c6_valid",  {31'b0, fetch_dec_valid},      32'h0);
    checkOutput("rd_c6_req",    {31'b0, fetch_imem_req},       32'h1);
    checkOutput("rd_c6_addr",   fetch_imem_addr,               32'h400);
    tick();
    checkOutput("rd_c7_valid",  {31'b0, fetch_dec_valid},      32'h0);
    checkOutput("rd_c7_addr",   fetch_imem_addr,               32'h404);
    tick();
    checkOutput("rd_c8_decpc",  fetch_dec_pc,                  32'h400);
    checkOutput("rd_c8_instr",  fetch_dec_instr,               ~32'h400);

    $display("[TB] wrap and reset");
    doReset(1'b1);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    checkOutput("wr_boot_req",  {31'b0, fetch_imem_req},       32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("wr_c1_req",    {31'b0, fetch_imem_req},       32'h1);
    checkOutput("wr_c1_addr",   fetch_imem_addr,               32'hFFFF_FFFC);
    tick();
    checkOutput("wr_c2_addr",   fetch_imem_addr,               32'h0);
    tick();
    checkOutput("wr_c3_addr",   fetch_imem_addr,               32'h4);
    checkOutput("wr_c3_decpc",  fetch_dec_pc,                  32'hFFFF_FFFC);
    checkOutput("wr_c3_instr",  fetch_dec_instr,               32'h3);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("wr_rst_req",   {31'b0, fetch_imem_req},       32'h0);
    checkOutput("wr_rst_valid", {31'b0, fetch_dec_valid},      32'h0);
    checkOutput("wr_rst_addr",  fetch_imem_addr,               32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("wr_r1_addr",   fetch_imem_addr,               32'h100);
    checkOutput("wr_r1_valid",  {31'b0, fetch_dec_valid},      32'h0);
    tick();
    checkOutput("wr_r2_addr",   fetch_imem_addr,               32'h104);
    checkOutput("wr_r2_valid",  {31'b0, fetch_dec_valid},      32'h0);
    tick();
    checkOutput("wr_r3_decpc",  fetch_dec_pc,                  32'h100);
    checkOutput("wr_r3_instr",  fetch_dec_instr,               ~32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end that owns the architectural fetch PC, issues one instruction-memory request per cycle, looks up the branch target buffer with the same address, and uses the BTB's next-cycle hit/target to choose the following fetch address with zero bubble. It buffers fetched instructions with their prediction in a small queue for decode, and accepts redirects from execute on a misprediction.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `FQ_DEPTH`, default 4: fetch-queue entries, power of two, minimum 2.
- `fetch_clk` in 1: single clock, rising edge.
- `fetch_reset` in 1: synchronous, active-high reset.
- `fetch_redirect` in 1: execute-stage redirect strobe.
- `fetch_redirect_pc` in 32: corrected PC.
- `fetch_btb_pc` out 32: BTB lookup address, always equal to `fetch_imem_addr`.
- `fetch_btb_hit` in 1: BTB hit for the lookup issued the previous cycle.
- `fetch_btb_target` in 32: predicted target for that lookup.
- `fetch_imem_req` out 1: memory request valid.
- `fetch_imem_addr` out 32: request address, word aligned.
- `fetch_imem_ready` in 1: request accepted when high together with req.
- `fetch_imem_rdata` in 32: instruction, valid exactly one cycle after acceptance.
- `fetch_dec_valid` out 1: queue head valid.
- `fetch_dec_ready` in 1: decode consumes head when valid && ready.
- `fetch_dec_pc` out 32, `fetch_dec_instr` out 32: head PC and instruction.
- `fetch_dec_pred_taken` out 1, `fetch_dec_pred_target` out 32: prediction attached to the head.

## Operation
- Registers: `pc_reg` (32), `look_pend` (1, an accepted request is outstanding), `look_pc` (32), queue (pc, instr, pred_taken, pred_target), `count` (log2(FQ_DEPTH)+1 bits), FSM state.
- FSM: BOOT and RUN.
  - Reset enters BOOT, where req=0.
  - BOOT moves to RUN next cycle.
  - RUN has no exit except reset.
- Next fetch address: `nf = (look_pend && fetch_btb_hit) ? fetch_btb_target : pc_reg`. It is combinational, and `fetch_imem_addr = fetch_btb_pc = nf`.
- Issue condition in RUN: `count + look_pend - deq < FQ_DEPTH` and no redirect. Here `deq` is the decode handshake this cycle.
- `pc_reg` update:
  - On acceptance: `pc_reg <= nf + 4`. PC arithmetic is mod 2^32; 32'hFFFF_FFFC wraps to 0.
  - Not accepted: `pc_reg <= nf`, so a taken prediction is held while memory stalls.
- Enqueue when `look_pend` is set: {look_pc, rdata, btb_hit, btb_target} is written. `look_pend <= accepted`, and `look_pc <= nf` on acceptance.
- Enqueue and dequeue in the same cycle are both allowed. The credit rule makes enqueue into a full queue impossible; an assertion flags a violation.
- Redirect takes priority over everything else.
  - In that cycle: req=0, queue flushed (count=0), the pending response is discarded (no enqueue), `look_pend <= 0`, `pc_reg <= fetch_redirect_pc`.
  - `fetch_dec_valid` still reflects the pre-flush head that cycle, but a dequeue that cycle is void.
- Redirect in BOOT loads `pc_reg`, and RUN still starts next cycle.
- Misaligned `redirect_pc`/`btb_target`: bits [1:0] are forced to 0.

## Timing
- Reset values:
  - Outputs: req=0, `fetch_dec_valid`=0, `fetch_dec_pred_taken`=0, `fetch_dec_pc`/`instr`/`pred_target`=0.
  - Internal: `pc_reg`=RESET_PC, `look_pend`=0, count=0.
- First request is the 2nd cycle after reset deasserts (BOOT, then RUN).
- Throughput is 1 instruction/cycle with ready memory and ready decode, including across predicted-taken branches (0 bubbles).
- Fetch-to-decode latency is 2 cycles: issue in N, enqueue at end of N+1, head visible in N+2.
- Redirect penalty: redirect in N, new PC issued in N+1, visible to decode in N+3.
- Reset mid-operation (any state, pending response, full queue) clears everything within the reset cycle; the response that arrives the next cycle is ignored.

## Structure
- Shared package `fetch_pkg`: `fetch_entry_t` struct (pc, instr, pred_taken, pred_target), `INSTR_BYTES = 4`, FSM state enum.
- Sub-module `fetch_queue`: synchronous FIFO with flush, count output, and parameter FQ_DEPTH. The FSM, PC logic and credit logic stay in `fetch_pc_unit`.

## Test plan
- **Reset and boot:** RESET_PC=0x100, memory always ready, no BTB hits → requests to 0x100, 0x104, 0x108 on consecutive cycles starting cycle 2; decode sees the same PCs with pred_taken=0.
- **Predicted taken:** BTB hits for 0x104 with target 0x200 → issue sequence 0x100, 0x104, 0x200, 0x204 with no gap; entry 0x104 has pred_taken=1, pred_target=0x200.
- **Memory stall after hit:** `fetch_imem_ready`=0 for 3 cycles right after a hit to 0x200 → addr holds 0x200 for all 3 cycles, then 0x204 follows.
- **Backpressure:** FQ_DEPTH=4, `fetch_dec_ready`=0 → exactly 4 requests are accepted, then req=0; each cycle of ready=1 restores one issue; no entry is lost or duplicated.
- **Redirect with pending response:** redirect to 0x400 while the queue is full and a response is pending → dec_valid=0 next cycle, the stale response is dropped, next request is 0x400 and decode's first PC is 0x400.
- **Wrap and reset:** PC=0xFFFF_FFFC advances to 0x0; asserting reset mid-stream → only RESET_PC-based fetches appear afterwards.
